sid_write_scheduler: RTL and testbench
======================================

# sid_write_scheduler

Sequences SID register writes between the shadow register RAM and the SID bus. The SPI slave writes the RAM; this block tracks which registers changed and replays only those. It issues at most one SID bus write per `sid_clk` period, in round-robin order, with bus timing aligned to the 1 MHz `sid_clk` from the clock divider. It also owns the SID power-on reset sequence and sits between the SPI/RAM path and the SID pins.

## Interface
- `NUM_REGS`, 25: writable SID registers 0x00–0x18; addresses ≥ `NUM_REGS` are read-only and never scheduled.
- `ADDR_BITS`, 5: register address width.
- `RESET_CYCLES`, 10: number of `sid_clk` rising edges for which `sid_rst` is held low.

- `clk` in 1: 20 MHz system clock; the only clock.
- `rst_n` in 1: reset, synchronous, active-low.
- `sid_clk` in 1: 1 MHz SID clock level, synchronous to `clk`.
- `wr_stb` in 1: one-cycle pulse; the RAM was written at `wr_addr` on this edge.
- `wr_addr` in `ADDR_BITS`: address written.
- `flush` in 1: one-cycle pulse; marks all registers dirty.
- `rd_addr` out `ADDR_BITS`: RAM read address.
- `ram_out` in 8: RAM read data, valid 1 `clk` after `rd_addr`.
- `sid_addr` out `ADDR_BITS`, `sid_data` out 8: SID bus address and data.
- `sid_cs` out 1: SID chip select, active-low.
- `sid_rw` out 1: SID read/write; 0 = write.
- `sid_rst` out 1: SID reset, active-low.
- `busy` out 1: high while in reset sequence or while any register is dirty or in flight.
- `overrun` out 1: sticky; a write arrived for a register that was still dirty (coalesced).

## Operation
- Edge detect: `sid_clk_q` register. `rise = sid_clk & ~sid_clk_q`. `fall = ~sid_clk & sid_clk_q`.
- `dirty[NUM_REGS-1:0]`:
  - Set by `wr_stb` when `wr_addr < NUM_REGS`. Set entirely by `flush`.
  - Cleared for the selected register on entry to FETCH.
  - If a set and a clear hit the same bit in the same cycle, the set wins.
- `overrun` sets when `wr_stb` hits a bit already set. It is cleared only by reset.
- Picker: round-robin. Search starts at `last + 1` and wraps from `NUM_REGS-1` to 0. `last` resets to `NUM_REGS-1`, so the first pick is reg 0.
- States:
  - RESET: `sid_rst=0`. Counts `rise` events. At `RESET_CYCLES` → IDLE with `sid_rst=1`. `wr_stb` and `flush` still set dirty bits during RESET.
  - IDLE: if any bit is dirty → FETCH with `rd_addr = pick`, and the picked bit clears. Otherwise stay.
  - FETCH, 1 cycle: → LOAD.
  - LOAD, 1 cycle: `sid_addr <= rd_addr`, `sid_data <= ram_out` → WAIT_RISE.
  - WAIT_RISE: on `rise` → STROBE with `sid_cs=0` and `sid_rw=0`.
  - STROBE: on `fall` → IDLE with `sid_cs=1`, `sid_rw=1`, `last <= sid_addr`.
- A write to the register currently in flight (after FETCH) re-marks it dirty. It is written again later with the new data.
- `sid_addr` and `sid_data` hold their value outside STROBE; they only change in LOAD.
- Reset values: `sid_cs=1`, `sid_rw=1`, `sid_rst=0`, `sid_addr=0`, `sid_data=0`, `rd_addr=0`, `dirty=0`, `busy=1`, `overrun=0`, state RESET.
- Reset asserted mid-write: on the next `clk` edge the block drops `sid_cs` high and returns to RESET. All dirty bits are lost.

## Timing
- All outputs are registered.
- Write path:
  - `wr_stb` at edge t makes the dirty bit visible at t+1.
  - From IDLE, FETCH runs at t+1 and LOAD at t+2.
  - `sid_cs` falls 1 `clk` after the first `rise` following t+2.
  - `sid_cs` rises 1 `clk` after the next `fall`.
- `sid_cs` low lasts exactly the `sid_clk`-high phase (10 `clk` at 20:1). `sid_addr`/`sid_data` are stable ≥1 `clk` before and after.
- Throughput: at most one write per `sid_clk` period, so all 25 registers flush in ≤ 25 periods (25 µs) plus pipeline delay.
- `busy` = state≠IDLE or `|dirty`, registered. It rises 1 `clk` after a `wr_stb` seen in IDLE.

## Structure
- Package `sid_pkg`:
  - State enum: RESET, IDLE, FETCH, LOAD, WAIT_RISE, STROBE.
  - `SID_NUM_REGS=25`, `SID_ADDR_BITS=5`, `SID_RESET_CYCLES=10`.
- Sub-module `sid_rr_picker`: combinational round-robin first-set search over `dirty` from `last+1`. Outputs `pick` and `any`.

## Test plan
- Reset: `rst_n` low 5 cycles then high → `sid_rst=0` for exactly 10 `sid_clk` rises, then 1. `sid_cs=1` throughout.
- Single write: RAM[0x04]=0x41, `wr_stb` addr 0x04 → one `sid_cs` pulse (10 `clk` wide) with `sid_addr=0x04`, `sid_data=0x41`, `sid_rw=0`. `busy` returns to 0.
- Round-robin and coalesce:
  - Writes to 0x18, 0x00, 0x18 (data 0x0F then 0x0A) → `overrun=1`.
  - Bus order is 0x00 then 0x18, with data 0x0A for 0x18 and exactly one write each.
- In-flight rewrite: `wr_stb` addr 0x07 during WAIT_RISE of the 0x07 write → 0x07 is written twice, and the second write carries the new data.
- Read-only and flush:
  - `wr_stb` addr 0x1B → no bus activity.
  - `flush` → 25 writes at addresses 0x00–0x18 in order, in 25 consecutive `sid_clk` periods.
- Reset mid-write: `rst_n` low during STROBE → `sid_cs=1` next `clk`, `dirty` cleared, reset sequence restarts.

Source files
------------

// File: rtl/sid_pkg.sv
`default_nettype none
// ============================================================================
// Module      : sid_pkg
// Description : Shared constants, scheduler state encoding and a small
//               wrap-around index helper for the SID write scheduler.
// Contents    : SID_NUM_REGS, SID_ADDR_BITS, SID_RESET_CYCLES,
//               sid_state_e, sid_wrap()
// Revision    : 1.0 - initial release
// ============================================================================
package sid_pkg;

    localparam int SID_NUM_REGS     = 25;
    localparam int SID_ADDR_BITS    = 5;
    localparam int SID_RESET_CYCLES = 10;

    typedef enum logic [2:0] {
        ST_RESET     = 3'd0,
        ST_IDLE      = 3'd1,
        ST_FETCH     = 3'd2,
        ST_LOAD      = 3'd3,
        ST_WAIT_RISE = 3'd4,
        ST_STROBE    = 3'd5
    } sid_state_e;

    // (base + offset) mod n; n is always an elaboration-time constant.
    function automatic int sid_wrap(input int base, input int offset, input int n);
        return (base + offset) % n;
    endfunction

endpackage : sid_pkg
`default_nettype wire

// File: rtl/sid_rr_picker.sv
`default_nettype none
// ============================================================================
// Module      : sid_rr_picker
// Description : Combinational round-robin first-set search over the dirty
//               vector, starting one past the last register written and
//               wrapping from NUM_REGS-1 to 0.
// Ports       : dirty_i  - per-register dirty flags
//               last_i   - address of the most recently written register
//               pick_o   - first dirty register at or after last_i+1
//               any_o    - at least one register is dirty
// Revision    : 1.0 - initial release
// ============================================================================
module sid_rr_picker
    import sid_pkg::*;
#(
    parameter int NUM_REGS  = SID_NUM_REGS,
    parameter int ADDR_BITS = SID_ADDR_BITS
) (
    input  logic [NUM_REGS-1:0]  dirty_i,
    input  logic [ADDR_BITS-1:0] last_i,
    output logic [ADDR_BITS-1:0] pick_o,
    output logic                 any_o
);

    logic [ADDR_BITS-1:0] w_idx;

    // Offsets 1..NUM_REGS visit every register once; last_i itself is
    // checked last, so a lone re-dirtied register is still found.
    always_comb begin
        pick_o = '0;
        any_o  = 1'b0;
        w_idx  = '0;
        for (int i = 1; i <= NUM_REGS; i++) begin
            w_idx = ADDR_BITS'(sid_wrap(int'(last_i), i, NUM_REGS));
            if (!any_o && dirty_i[w_idx]) begin
                any_o  = 1'b1;
                pick_o = w_idx;
            end
        end
    end

endmodule : sid_rr_picker
`default_nettype wire

// File: rtl/sid_write_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : sid_write_scheduler
// Description : Replays changed SID shadow registers onto the SID bus, one
//               write per sid_clk period in round-robin order, and owns the
//               SID power-on reset sequence.
// Ports       : clk_i      - system clock (20 MHz)
//               rst_ni     - synchronous active-low reset
//               sid_clk_i  - 1 MHz SID clock level, synchronous to clk_i
//               wr_stb_i   - shadow RAM written at wr_addr_i this cycle
//               wr_addr_i  - address written
//               flush_i    - mark every register dirty
//               rd_addr_o  - shadow RAM read address
//               ram_out_i  - shadow RAM read data (1 clk latency)
//               sid_addr_o - SID bus address
//               sid_data_o - SID bus data
//               sid_cs_o   - SID chip select, active-low
//               sid_rw_o   - SID read/write, 0 = write
//               sid_rst_o  - SID reset, active-low
//               busy_o     - reset sequence running or work outstanding
//               overrun_o  - sticky: a write coalesced into a dirty register
// Revision    : 1.0 - initial release
// ============================================================================
module sid_write_scheduler
    import sid_pkg::*;
#(
    parameter int NUM_REGS     = SID_NUM_REGS,
    parameter int ADDR_BITS    = SID_ADDR_BITS,
    parameter int RESET_CYCLES = SID_RESET_CYCLES
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 sid_clk_i,
    input  logic                 wr_stb_i,
    input  logic [ADDR_BITS-1:0] wr_addr_i,
    input  logic                 flush_i,
    output logic [ADDR_BITS-1:0] rd_addr_o,
    input  logic [7:0]           ram_out_i,
    output logic [ADDR_BITS-1:0] sid_addr_o,
    output logic [7:0]           sid_data_o,
    output logic                 sid_cs_o,
    output logic                 sid_rw_o,
    output logic                 sid_rst_o,
    output logic                 busy_o,
    output logic                 overrun_o
);

    localparam int CNT_W = $clog2(RESET_CYCLES + 1);

    sid_state_e           state_q, state_d;
    logic                 sid_clk_q;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [NUM_REGS-1:0]  dirty_q, dirty_d;
    logic [ADDR_BITS-1:0] last_q, last_d;
    logic [ADDR_BITS-1:0] rd_addr_q, rd_addr_d;
    logic [ADDR_BITS-1:0] sid_addr_q, sid_addr_d;
    logic [7:0]           sid_data_q, sid_data_d;
    logic                 cs_q, cs_d;
    logic                 rw_q, rw_d;
    logic                 sid_rst_q, sid_rst_d;
    logic                 busy_q;
    logic                 overrun_q, overrun_d;

    logic                 w_rise;
    logic                 w_fall;
    logic                 w_wr_valid;
    logic                 w_clr;
    logic [ADDR_BITS-1:0] w_pick;
    logic                 w_any;

    // Edge detector is left out of reset so that a sid_clk already high at
    // reset release is not mistaken for a fresh rising edge.
    always_ff @(posedge clk_i) begin
        sid_clk_q <= sid_clk_i;
    end

    assign w_rise     = sid_clk_i & ~sid_clk_q;
    assign w_fall     = ~sid_clk_i & sid_clk_q;
    assign w_wr_valid = wr_stb_i && (wr_addr_i < ADDR_BITS'(NUM_REGS));

    sid_rr_picker #(
        .NUM_REGS  (NUM_REGS),
        .ADDR_BITS (ADDR_BITS)
    ) u_picker (
        .dirty_i (dirty_q),
        .last_i  (last_q),
        .pick_o  (w_pick),
        .any_o   (w_any)
    );

    // Sequencer: next state and registered bus outputs.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        last_d     = last_q;
        rd_addr_d  = rd_addr_q;
        sid_addr_d = sid_addr_q;
        sid_data_d = sid_data_q;
        cs_d       = cs_q;
        rw_d       = rw_q;
        sid_rst_d  = sid_rst_q;
        w_clr      = 1'b0;

        case (state_q)
            ST_RESET: begin
                sid_rst_d = 1'b0;
                if (w_rise) begin
                    if (cnt_q == CNT_W'(RESET_CYCLES - 1)) begin
                        state_d   = ST_IDLE;
                        sid_rst_d = 1'b1;
                        cnt_d     = '0;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            ST_IDLE: begin
                if (w_any) begin
                    state_d   = ST_FETCH;
                    rd_addr_d = w_pick;
                    w_clr     = 1'b1;
                end
            end
            ST_FETCH: begin
                // RAM read data for rd_addr is valid in the next cycle.
                state_d = ST_LOAD;
            end
            ST_LOAD: begin
                sid_addr_d = rd_addr_q;
                sid_data_d = ram_out_i;
                state_d    = ST_WAIT_RISE;
            end
            ST_WAIT_RISE: begin
                if (w_rise) begin
                    cs_d    = 1'b0;
                    rw_d    = 1'b0;
                    state_d = ST_STROBE;
                end
            end
            ST_STROBE: begin
                if (w_fall) begin
                    cs_d    = 1'b1;
                    rw_d    = 1'b1;
                    last_d  = sid_addr_q;
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_RESET;
            end
        endcase
    end

    // Dirty tracking. Ordering makes a same-cycle set win over the clear of
    // the register being fetched, so a rewrite during its own fetch is kept.
    always_comb begin
        dirty_d = dirty_q;
        if (w_clr) begin
            dirty_d[w_pick] = 1'b0;
        end
        if (flush_i) begin
            dirty_d = '1;
        end
        if (w_wr_valid) begin
            dirty_d[wr_addr_i] = 1'b1;
        end
    end

    always_comb begin
        overrun_d = overrun_q;
        if (w_wr_valid && dirty_q[wr_addr_i]) begin
            overrun_d = 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q    <= ST_RESET;
            cnt_q      <= '0;
            dirty_q    <= '0;
            last_q     <= ADDR_BITS'(NUM_REGS - 1);
            rd_addr_q  <= '0;
            sid_addr_q <= '0;
            sid_data_q <= '0;
            cs_q       <= 1'b1;
            rw_q       <= 1'b1;
            sid_rst_q  <= 1'b0;
            busy_q     <= 1'b1;
            overrun_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            dirty_q    <= dirty_d;
            last_q     <= last_d;
            rd_addr_q  <= rd_addr_d;
            sid_addr_q <= sid_addr_d;
            sid_data_q <= sid_data_d;
            cs_q       <= cs_d;
            rw_q       <= rw_d;
            sid_rst_q  <= sid_rst_d;
            busy_q     <= (state_q != ST_IDLE) || (|dirty_q);
            overrun_q  <= overrun_d;
        end
    end

    assign rd_addr_o  = rd_addr_q;
    assign sid_addr_o = sid_addr_q;
    assign sid_data_o = sid_data_q;
    assign sid_cs_o   = cs_q;
    assign sid_rw_o   = rw_q;
    assign sid_rst_o  = sid_rst_q;
    assign busy_o     = busy_q;
    assign overrun_o  = overrun_q;

endmodule : sid_write_scheduler
`default_nettype wire

// File: tb/tb_sid_write_scheduler.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : tb_sid_write_scheduler
// Description : Directed self-checking bench for sid_write_scheduler with a
//               one-cycle-latency shadow RAM model and a SID bus monitor.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sid_write_scheduler;

    logic       clk;
    logic       rst_n;
    logic       sid_clk;
    logic       wr_stb;
    logic [4:0] wr_addr;
    logic       flush;
    logic [4:0] rd_addr;
    logic [7:0] ram_out;
    logic [4:0] sid_addr;
    logic [7:0] sid_data;
    logic       sid_cs;
    logic       sid_rw;
    logic       sid_rst;
    logic       busy;
    logic       overrun;

    logic [7:0] mem [0:31];

    int vectors     = 0;
    int miscompares = 0;
    int ph          = 0;

    sid_write_scheduler dut (
        .clk_i      (clk),
        .rst_ni     (rst_n),
        .sid_clk_i  (sid_clk),
        .wr_stb_i   (wr_stb),
        .wr_addr_i  (wr_addr),
        .flush_i    (flush),
        .rd_addr_o  (rd_addr),
        .ram_out_i  (ram_out),
        .sid_addr_o (sid_addr),
        .sid_data_o (sid_data),
        .sid_cs_o   (sid_cs),
        .sid_rw_o   (sid_rw),
        .sid_rst_o  (sid_rst),
        .busy_o     (busy),
        .overrun_o  (overrun)
    );

    // 20 MHz clk; sid_clk = clk/20, changing 10 ns after each rising edge so
    // it is stable at both the sampling negedge and the DUT posedge.
    initial begin
        clk     = 1'b0;
        sid_clk = 1'b0;
        forever begin
            #25 clk = 1'b1;
            #10 ph = (ph + 1) % 20;
            sid_clk = (ph >= 10);
            #15 clk = 1'b0;
        end
    end

    always @(posedge clk) ram_out <= mem[rd_addr];

    // SID bus monitor
    logic [4:0] cap_addr  [$];
    logic [7:0] cap_data  [$];
    logic       cap_rw    [$];
    int         cap_start [$];
    int         cap_width [$];
    int         stable_err = 0;

    initial begin
        int         cyc;
        int         cur_w;
        logic       prev_cs;
        logic [4:0] cur_addr;
        logic [7:0] cur_data;
        cyc = 0; cur_w = 0; prev_cs = 1'b1; cur_addr = '0; cur_data = '0;
        forever begin
            @(negedge clk);
            cyc++;
            if (prev_cs === 1'b1 && sid_cs === 1'b0) begin
                cap_addr.push_back(sid_addr);
                cap_data.push_back(sid_data);
                cap_rw.push_back(sid_rw);
                cap_start.push_back(cyc);
                cur_w = 1; cur_addr = sid_addr; cur_data = sid_data;
            end else if (sid_cs === 1'b0) begin
                cur_w++;
                if (sid_addr !== cur_addr || sid_data !== cur_data) stable_err++;
            end else if (prev_cs === 1'b0 && sid_cs === 1'b1) begin
                cap_width.push_back(cur_w);
                if (sid_addr !== cur_addr || sid_data !== cur_data) stable_err++;
            end
            prev_cs = sid_cs;
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Called at a negedge: strobe for exactly one DUT edge.
    task automatic write_reg(input logic [4:0] a, input logic [7:0] d);
        mem[a]  = d;
        wr_addr = a;
        wr_stb  = 1'b1;
        @(negedge clk);
        wr_stb  = 1'b0;
    endtask

    task automatic clear_caps();
        cap_addr.delete(); cap_data.delete(); cap_rw.delete();
        cap_start.delete(); cap_width.delete();
        stable_err = 0;
    endtask

    task automatic wait_idle(input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (busy === 1'b0 && sid_cs === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
        tick(2);
    endtask

    // Leaves rst_n low with the bench on a negedge.
    task automatic assert_reset();
        @(negedge clk);
        rst_n = 1'b0;
        tick(4);
    endtask

    task automatic release_and_count(output int rises, output bit cs_low, output bit ok);
        logic p;
        p = sid_clk;
        @(negedge clk);
        rst_n  = 1'b1;
        rises  = 0;
        cs_low = 1'b0;
        ok     = 1'b0;
        for (int i = 0; i < 400; i++) begin
            if (sid_rst === 1'b1) begin
                ok = 1'b1;
                break;
            end
            if (sid_clk === 1'b1 && p === 1'b0) rises++;
            if (sid_cs !== 1'b1) cs_low = 1'b1;
            p = sid_clk;
            @(negedge clk);
        end
    endtask

    initial begin
        int rises;
        bit cs_low;
        bit ok;

        rst_n = 1'b0; wr_stb = 1'b0; wr_addr = '0; flush = 1'b0;
        for (int i = 0; i < 32; i++) mem[i] = 8'h00;

        // ---- reset values and reset sequence ----
        assert_reset();
        check("rst_sid_rst",  {31'd0, sid_rst},  32'd0);
        check("rst_sid_cs",   {31'd0, sid_cs},   32'd1);
        check("rst_sid_rw",   {31'd0, sid_rw},   32'd1);
        check("rst_busy",     {31'd0, busy},     32'd1);
        check("rst_overrun",  {31'd0, overrun},  32'd0);
        check("rst_sid_addr", {27'd0, sid_addr}, 32'd0);
        check("rst_sid_data", {24'd0, sid_data}, 32'd0);
        check("rst_rd_addr",  {27'd0, rd_addr},  32'd0);
        release_and_count(rises, cs_low, ok);
        check("rst_seq_done",   {31'd0, ok},     32'd1);
        check("rst_rise_count", rises,           32'd10);
        check("rst_cs_held",    {31'd0, cs_low}, 32'd0);
        tick(2);
        check("rst_busy_clear", {31'd0, busy},   32'd0);

        // ---- single write ----
        clear_caps();
        write_reg(5'h04, 8'h41);
        @(negedge clk);
        check("single_busy_rise", {31'd0, busy}, 32'd1);
        wait_idle(200, ok);
        check("single_idle", {31'd0, ok}, 32'd1);
        check("single_count", cap_addr.size(), 32'd1);
        if (cap_addr.size() >= 1 && cap_width.size() >= 1) begin
            check("single_addr",  {27'd0, cap_addr[0]}, 32'h04);
            check("single_data",  {24'd0, cap_data[0]}, 32'h41);
            check("single_rw",    {31'd0, cap_rw[0]},   32'd0);
            check("single_width", cap_width[0],         32'd10);
        end
        check("single_stable",  stable_err,          32'd0);
        check("single_busy0",   {31'd0, busy},       32'd0);
        check("single_overrun", {31'd0, overrun},    32'd0);

        // ---- in-flight rewrite ----
        clear_caps();
        write_reg(5'h07, 8'h11);
        ok = 1'b0;
        for (int i = 0; i < 60; i++) begin
            if (sid_addr === 5'h07) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        check("inflight_loaded", {31'd0, ok},     32'd1);
        check("inflight_cs_hi",  {31'd0, sid_cs}, 32'd1);
        write_reg(5'h07, 8'h22);
        wait_idle(200, ok);
        check("inflight_idle",  {31'd0, ok}, 32'd1);
        check("inflight_count", cap_addr.size(), 32'd2);
        if (cap_addr.size() >= 2) begin
            check("inflight_addr0", {27'd0, cap_addr[0]}, 32'h07);
            check("inflight_data0", {24'd0, cap_data[0]}, 32'h11);
            check("inflight_addr1", {27'd0, cap_addr[1]}, 32'h07);
            check("inflight_data1", {24'd0, cap_data[1]}, 32'h22);
        end
        check("inflight_overrun", {31'd0, overrun}, 32'd0);

        // ---- read-only address ----
        clear_caps();
        write_reg(5'h1B, 8'h77);
        tick(2);
        check("ro_busy", {31'd0, busy}, 32'd0);
        tick(60);
        check("ro_count",   cap_addr.size(), 32'd0);
        check("ro_busy_end", {31'd0, busy},   32'd0);

        // ---- round-robin and coalesce, queued during the reset sequence ----
        assert_reset();
        @(negedge clk);
        rst_n = 1'b1;
        clear_caps();
        write_reg(5'h18, 8'h0F);
        write_reg(5'h00, 8'h55);
        write_reg(5'h18, 8'h0A);
        tick(1);
        check("rr_overrun",   {31'd0, overrun}, 32'd1);
        check("rr_in_reset",  {31'd0, sid_rst}, 32'd0);
        wait_idle(600, ok);
        check("rr_idle",  {31'd0, ok}, 32'd1);
        check("rr_count", cap_addr.size(), 32'd2);
        if (cap_addr.size() >= 2) begin
            check("rr_addr0", {27'd0, cap_addr[0]}, 32'h00);
            check("rr_data0", {24'd0, cap_data[0]}, 32'h55);
            check("rr_addr1", {27'd0, cap_addr[1]}, 32'h18);
            check("rr_data1", {24'd0, cap_data[1]}, 32'h0A);
        end

        // ---- flush: 25 writes in consecutive sid_clk periods ----
        clear_caps();
        for (int i = 0; i < 25; i++) mem[i] = 8'((i * 7) + 3);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        wait_idle(800, ok);
        check("flush_idle",  {31'd0, ok}, 32'd1);
        check("flush_count", cap_addr.size(), 32'd25);
        for (int i = 0; i < 25 && i < cap_addr.size(); i++) begin
            check($sformatf("flush_addr%0d", i), {27'd0, cap_addr[i]}, i);
            check($sformatf("flush_data%0d", i), {24'd0, cap_data[i]}, (i * 7) + 3);
            if (i > 0)
                check($sformatf("flush_period%0d", i), cap_start[i] - cap_start[i-1], 32'd20);
        end
        check("flush_stable", stable_err, 32'd0);

        // ---- reset during STROBE ----
        check("mid_overrun_before", {31'd0, overrun}, 32'd1);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        ok = 1'b0;
        for (int i = 0; i < 100; i++) begin
            if (sid_cs === 1'b0) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        check("mid_strobe_seen", {31'd0, ok}, 32'd1);
        rst_n = 1'b0;
        @(negedge clk);
        check("mid_cs_high",  {31'd0, sid_cs},   32'd1);
        check("mid_sid_rst",  {31'd0, sid_rst},  32'd0);
        check("mid_busy",     {31'd0, busy},     32'd1);
        check("mid_overrun",  {31'd0, overrun},  32'd0);
        check("mid_sid_addr", {27'd0, sid_addr}, 32'd0);
        tick(3);
        release_and_count(rises, cs_low, ok);
        check("mid_seq_done",   {31'd0, ok},     32'd1);
        check("mid_rise_count", rises,           32'd10);
        clear_caps();
        tick(60);
        check("mid_no_writes", cap_addr.size(), 32'd0);
        check("mid_busy_end",  {31'd0, busy},   32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule : tb_sid_write_scheduler
`default_nettype wire
